// File: rtl/program_loader_pkg.sv
// Shared definitions for the UART program loader: default sizes and the loader state enum.
package program_loader_pkg;

    localparam int INST_WIDTH_DEFAULT     = 32;
    localparam int INST_MEM_WIDTH_DEFAULT = 14;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        LOAD,
        CHECK,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Assembles a UART byte stream (count header + big-endian words) into instruction memory writes.
// Optional trailing-checksum verification is enabled by defining LOADER_CHECKSUM_EN.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INST_WIDTH     = INST_WIDTH_DEFAULT,
    parameter int INST_MEM_WIDTH = INST_MEM_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  we,
    output logic                  reset_pc,
    output logic                  stall,
    output logic                  loaded,
    output logic                  error
);

    localparam int BYTES = INST_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [INST_WIDTH:0] MAX_WORDS = (INST_WIDTH + 1)'(1) << INST_MEM_WIDTH;
    localparam logic [INST_MEM_WIDTH:0] ONE_WORD = (INST_MEM_WIDTH + 1)'(1);

    loader_state_t           state;
    loader_state_t           next_state;
    logic [INST_WIDTH-1:0]   word_reg;
    logic [INST_WIDTH-1:0]   shifted;
    logic [CNT_W-1:0]        byte_cnt;
    logic [CNT_W-1:0]        next_cnt;
    logic [INST_MEM_WIDTH:0] remaining;
    logic                    last_byte;
    logic                    last_we;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              sum;
`endif

    assign shifted   = (word_reg << 8) | INST_WIDTH'(rx_data);
    assign last_byte = (byte_cnt == LAST_BYTE);
    assign next_cnt  = last_byte ? '0 : byte_cnt + CNT_W'(1);
    assign last_we   = we && (remaining == ONE_WORD);

    assign stall  = ((state == HEADER) || (state == LOAD) || (state == CHECK)) && !we;
    assign loaded = (state == DONE);
    assign error  = (state == ERROR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A byte arriving alongside the final we is the checksum byte, so it is judged right away.
    always_comb begin
        next_state = state;
        reset_pc   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    next_state = HEADER;
                    reset_pc   = 1'b1;
                end
            end
            HEADER: begin
                if (rx_valid && last_byte) begin
                    if ({1'b0, shifted} > MAX_WORDS) begin
                        next_state = ERROR;
                    end else if (shifted == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = CHECK;
`else
                        next_state = DONE;
`endif
                    end else begin
                        next_state = LOAD;
                    end
                end
            end
            LOAD: begin
                if (last_we) begin
`ifdef LOADER_CHECKSUM_EN
                    if (rx_valid) begin
                        next_state = (rx_data == sum) ? DONE : ERROR;
                    end else begin
                        next_state = CHECK;
                    end
`else
                    next_state = DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
                if (rx_valid) begin
                    next_state = (rx_data == sum) ? DONE : ERROR;
                end
            end
`endif
            default: next_state = state;
        endcase
        if (reset) begin
            reset_pc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_reg  <= '0;
            byte_cnt  <= '0;
            remaining <= '0;
            inst_out  <= '0;
            we        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            we <= 1'b0;
            if (we) begin
                remaining <= remaining - ONE_WORD;
            end
            case (state)
                IDLE, HEADER: begin
                    if (rx_valid) begin
                        word_reg <= shifted;
                        byte_cnt <= next_cnt;
                        if (state == HEADER && last_byte) begin
                            remaining <= shifted[INST_MEM_WIDTH:0];
                        end
                    end
                end
                LOAD: begin
                    if (rx_valid && !last_we) begin
                        word_reg <= shifted;
                        byte_cnt <= next_cnt;
`ifdef LOADER_CHECKSUM_EN
                        sum      <= sum + rx_data;
`endif
                        if (last_byte) begin
                            inst_out <= shifted;
                            we       <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader; checksum cases are included when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    localparam int IW  = 32;
    localparam int IMW = 14;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CKSUM = 1'b1;
`else
    localparam bit CKSUM = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic [IW-1:0] inst_out;
    logic          we;
    logic          reset_pc;
    logic          stall;
    logic          loaded;
    logic          error;

    int          checks = 0;
    int          failures = 0;
    int          rpc_count = 0;
    bit          stall_watch = 1'b0;
    logic [7:0]  stream_q[$];
    logic [31:0] words_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    program_loader #(
        .INST_WIDTH(IW),
        .INST_MEM_WIDTH(IMW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .inst_out(inst_out),
        .we(we),
        .reset_pc(reset_pc),
        .stall(stall),
        .loaded(loaded),
        .error(error)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Outputs are sampled mid-cycle; every write must match the oldest expected word.
    always @(negedge clk) begin
        logic [31:0] exp_word;
        if (reset_pc) rpc_count++;
        if (stall_watch) checkOutput("stall_vs_we", 64'(stall), 64'(!we));
        if (we) begin
            if (exp_q.size() == 0) begin
                checkOutput("we_unexpected", 64'(we), 64'd0);
            end else begin
                exp_word = exp_q.pop_front();
                checkOutput("inst_out", 64'(inst_out), 64'(exp_word));
            end
        end
    end

    function automatic void buildStream(input longint n, input bit add_cksum,
                                        input bit override_en, input logic [7:0] override_val);
        logic [31:0] hdr;
        logic [7:0]  sum;
        hdr = n[31:0];
        sum = 8'h00;
        stream_q.delete();
        for (int b = 3; b >= 0; b--) stream_q.push_back(hdr[b*8 +: 8]);
        if (n <= (64'd1 << IMW)) begin
            for (int w = 0; w < int'(n) && w < words_q.size(); w++) begin
                for (int b = 3; b >= 0; b--) begin
                    stream_q.push_back(words_q[w][b*8 +: 8]);
                    sum = sum + words_q[w][b*8 +: 8];
                end
            end
        end
        if (add_cksum) stream_q.push_back(override_en ? override_val : sum);
    endfunction

    task automatic resetDut();
        @(posedge clk); #1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_inst_out", 64'(inst_out), 64'd0);
        checkOutput("rst_we", 64'(we), 64'd0);
        checkOutput("rst_reset_pc", 64'(reset_pc), 64'd0);
        checkOutput("rst_stall", 64'(stall), 64'd0);
        checkOutput("rst_loaded", 64'(loaded), 64'd0);
        checkOutput("rst_error", 64'(error), 64'd0);
        rpc_count   = 0;
        stall_watch = 1'b0;
        exp_q.delete();
    endtask

    // Drives stream_q, pushing each payload word to the scoreboard as its last byte goes out.
    task automatic applyStimulus(input int gap_max, input bit watch);
        int     len;
        longint hdr;
        bit     valid_n;
        int     payload_end;
        len         = stream_q.size();
        hdr         = {32'd0, stream_q[0], stream_q[1], stream_q[2], stream_q[3]};
        valid_n     = (hdr <= (64'd1 << IMW));
        payload_end = valid_n ? 3 + 4 * int'(hdr) : -10;
        for (int i = 0; i < len + 2; i++) begin
            if (gap_max > 0 && i < len) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk); #1;
                    rx_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            if (watch && i == 1) stall_watch = 1'b1;
            if (i == payload_end + 2) stall_watch = 1'b0;
            if (i < len) begin
                rx_valid = 1'b1;
                rx_data  = stream_q[i];
                if (valid_n && i >= 4 && i <= payload_end && ((i - 4) % 4) == 3)
                    exp_q.push_back({stream_q[i-3], stream_q[i-2], stream_q[i-1], stream_q[i]});
            end else begin
                rx_valid = 1'b0;
            end
        end
        stall_watch = 1'b0;
    endtask

    task automatic waitFinal(input string tag, input bit exp_loaded, input bit exp_error, input int exp_rpc);
        int t;
        t = 0;
        @(negedge clk);
        while (!(loaded || error) && t < 20) begin
            @(negedge clk);
            t++;
        end
        checkOutput({tag, "_loaded"}, 64'(loaded), 64'(exp_loaded));
        checkOutput({tag, "_error"}, 64'(error), 64'(exp_error));
        checkOutput({tag, "_pending_words"}, 64'(exp_q.size()), 64'd0);
        checkOutput({tag, "_reset_pc_pulses"}, 64'(rpc_count), 64'(exp_rpc));
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Two-word program with random idle gaps, then trailing bytes that must be ignored.
        resetDut();
        words_q = '{32'h11223344, 32'hAABBCCDD};
        buildStream(2, CKSUM, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) stream_q.push_back(8'($urandom_range(0, 255)));
        applyStimulus(3, 1'b0);
        waitFinal("two_words", 1'b1, 1'b0, 1);
        checkOutput("two_words_done_stall", 64'(stall), 64'd0);

        // Empty program.
        resetDut();
        words_q.delete();
        buildStream(0, CKSUM, 1'b0, 8'h00);
        applyStimulus(2, 1'b0);
        waitFinal("zero_words", 1'b1, 1'b0, 1);

        // Count one beyond memory capacity aborts; later bytes are ignored.
        resetDut();
        words_q.delete();
        buildStream((64'd1 << IMW) + 1, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 8; k++) stream_q.push_back(8'($urandom_range(0, 255)));
        applyStimulus(1, 1'b0);
        waitFinal("too_many", 1'b0, 1'b1, 1);
        checkOutput("too_many_stall", 64'(stall), 64'd0);

        // Three words back to back: stall may drop only on write cycles.
        resetDut();
        words_q = '{32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF};
        buildStream(3, CKSUM, 1'b0, 8'h00);
        applyStimulus(0, 1'b1);
        waitFinal("back_to_back", 1'b1, 1'b0, 1);

        // Reset in the middle of a word, then a clean single-word load.
        resetDut();
        words_q = '{32'h12345678};
        buildStream(1, 1'b0, 1'b0, 8'h00);
        while (stream_q.size() > 6) void'(stream_q.pop_back());
        applyStimulus(0, 1'b0);
        checkOutput("partial_loaded", 64'(loaded), 64'd0);
        exp_q.delete();
        resetDut();
        words_q = '{32'hDEADBEEF};
        buildStream(1, CKSUM, 1'b0, 8'h00);
        applyStimulus(2, 1'b0);
        waitFinal("after_reset", 1'b1, 1'b0, 1);

`ifdef LOADER_CHECKSUM_EN
        resetDut();
        words_q = '{32'h01020304};
        buildStream(1, 1'b1, 1'b1, 8'h0A);
        applyStimulus(1, 1'b0);
        waitFinal("cksum_good", 1'b1, 1'b0, 1);

        resetDut();
        words_q = '{32'h01020304};
        buildStream(1, 1'b1, 1'b1, 8'h0B);
        applyStimulus(1, 1'b0);
        waitFinal("cksum_bad", 1'b0, 1'b1, 1);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32, instruction word width in bits (multiple of 8).
REQ-002 SHALL have parameter INST_MEM_WIDTH, default 14, instruction memory address width.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port rx_valid  input  1  one received UART byte present this cycle, no backpressure.
REQ-006 SHALL have port rx_data  input  8  received byte.
REQ-007 SHALL have port inst_out  output  INST_WIDTH  assembled instruction word to the instruction memory.
REQ-008 SHALL have port we  output  1  write strobe, instruction memory writes inst_out at its current pc.
REQ-009 SHALL have port reset_pc  output  1  one-cycle pulse returning the instruction memory pc to 0.
REQ-010 SHALL have port stall  output  1  holds instruction memory pc; high throughout loading except on we cycles.
REQ-011 SHALL have port loaded  output  1  program fully written; core may run.
REQ-012 SHALL have port error  output  1  load aborted (bad count or, if enabled, bad checksum).

Function
REQ-013 SHALL accept at most one byte per cycle, only when rx_valid=1.
REQ-014 SHALL use the stream format: header of INST_WIDTH/8 bytes big-endian giving word count N, then N words, each INST_WIDTH/8 bytes big-endian.
REQ-015 SHALL implement states IDLE, HEADER, LOAD, CHECK, DONE, ERROR.
REQ-016 SHALL leave IDLE for HEADER on the first rx_valid byte, which is the header's first byte, and pulse reset_pc for exactly that cycle.
REQ-017 SHALL, in HEADER after the last header byte, go to ERROR if N > 2**INST_MEM_WIDTH, to CHECK/DONE if N=0, else to LOAD.
REQ-018 SHALL shift bytes into a word register MSB-first, using a byte counter of width clog2(INST_WIDTH/8) that wraps to 0 after each word.
REQ-019 SHALL present the completed word on inst_out and assert we with stall=0 for exactly one cycle, the cycle after the word's last byte arrives (latency 1).
REQ-020 SHALL decrement a remaining-word counter of width INST_MEM_WIDTH+1 on each we; after the we for the last word, SHALL go to CHECK if enabled, else DONE.
REQ-021 SHALL keep accepting a byte arriving in the same cycle as a we pulse without loss.
REQ-022 SHALL hold loaded=1 in DONE and error=1 in ERROR; both states SHALL be sticky until reset and SHALL ignore further bytes.
REQ-023 SHALL drive stall=1 in HEADER, LOAD and CHECK except we cycles, and stall=0 in IDLE, DONE and ERROR.
REQ-024 SHALL never assert we outside LOAD.

Reset
REQ-025 SHALL, on reset, including mid-load, enter IDLE, discard any partial word, and clear counters and checksum.
REQ-026 SHALL reset outputs to inst_out=0, we=0, reset_pc=0, stall=0, loaded=0, error=0.

Configuration
REQ-027 SHALL, with LOADER_CHECKSUM_EN defined, keep an 8-bit wrapping sum of all payload bytes (not header) and, in CHECK, compare it with the one trailing byte: equal -> DONE, unequal -> ERROR.
REQ-028 SHALL, without LOADER_CHECKSUM_EN, omit CHECK and the sum register, and go LOAD -> DONE directly.

Structure
REQ-029 SHALL take INST_WIDTH and INST_MEM_WIDTH defaults, and the loader state enum, from the shared common package.
REQ-030 SHALL be one module, with no sub-module.

Verification
REQ-031 SHALL pass: header 00 00 00 02, words 11223344 and AABBCCDD -> reset_pc on byte 1, we twice with inst_out 0x11223344 then 0xAABBCCDD, loaded=1.
REQ-032 SHALL pass: header N=0 -> no we, loaded=1 (no checksum), or loaded=1 after checksum byte 00 (checksum enabled).
REQ-033 SHALL pass: header N=2**INST_MEM_WIDTH+1 -> error=1, no we, later bytes ignored.
REQ-034 SHALL pass: back-to-back bytes every cycle for 3 words -> 3 we pulses with stall=0 only on those cycles, no bytes lost.
REQ-035 SHALL pass: reset after 2 payload bytes, then full 1-word stream 00000001 DEADBEEF -> single we with 0xDEADBEEF, loaded=1.
REQ-036 SHALL pass, with LOADER_CHECKSUM_EN: word 01020304 with checksum 0A -> loaded=1; with checksum 0B -> error=1.
